// File: rtl/twiddle_pkg.sv
// Shared definitions for the twiddle datapath: word-size selection,
// a ceil-log2 helper and the IEEE-754 encodings of 1.0.
package twiddle_pkg;

  localparam logic [31:0] ONE_SP = 32'h3f800000;
  localparam logic [63:0] ONE_DP = 64'h3ff0000000000000;

  // Floating-point word width: 0 selects single (32), anything else double (64).
  function automatic int SIZE(input int dbl);
    return (dbl != 0) ? 64 : 32;
  endfunction

  // Smallest r with 2**r >= n; returns 0 for n <= 1.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/twiddle.sv
// Combinational twiddle unit: theta in, {cos, sin} out.
// Small-angle form: cos(theta) ~ 1.0, sin(theta) ~ theta. The word layout
// is {cos, sin}, each the selected IEEE width.
module twiddle
  import twiddle_pkg::*;
#(
  parameter int double = 0,
  localparam int SZ = SIZE(double)
) (
  input  logic [SZ-1:0]   theta,
  output logic [2*SZ-1:0] result
);

  localparam logic [SZ-1:0] ONE = (double != 0) ? SZ'(ONE_DP) : SZ'(ONE_SP);

  assign result = {ONE, theta};

endmodule

// File: rtl/twiddle_rr_arb.sv
// Round-robin arbiter: rotating priority search starting at the pointer,
// pointer moves to one past the winner whenever a grant is issued.
// gnt is combinational, one-hot or zero, and forced to zero when en is low.
module twiddle_rr_arb
  import twiddle_pkg::*;
#(
  parameter int NREQ = 2,
  localparam int IDW = (clog2(NREQ) < 1) ? 1 : clog2(NREQ)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic            en,
  output logic [NREQ-1:0] gnt
);

  logic [IDW-1:0] ptr;
  logic [IDW-1:0] gidx;
  logic [IDW:0]   pos;
  logic           found;

  // Rotating priority encode: first requester at or after ptr, wrapping.
  always_comb begin
    gnt   = '0;
    gidx  = '0;
    found = 1'b0;
    pos   = '0;
    for (int j = 0; j < NREQ; j++) begin
      pos = {1'b0, ptr} + (IDW+1)'(j);
      if (pos >= (IDW+1)'(NREQ)) pos = pos - (IDW+1)'(NREQ);
      if (en && !found && req[pos[IDW-1:0]]) begin
        found = 1'b1;
        gidx  = pos[IDW-1:0];
      end
    end
    if (found) gnt[gidx] = 1'b1;
  end

  // Pointer advances past the winner on a grant, otherwise holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (found) begin
      ptr <= (gidx == IDW'(NREQ - 1)) ? '0 : gidx + 1'b1;
    end
  end

endmodule

// File: rtl/twiddle_arbiter.sv
// Shares one combinational twiddle unit between NREQ requesters.
// Two registered stages: S1 {v1,id1,theta1} feeds the twiddle unit,
// S2 {v2,id2,result2} drives the response bus.
// Optional build macro: TWIDDLE_ARB_STATS_EN adds grant/stall counters.
//
// Handshake rule (both sides): a transfer happens on a rising edge where
// valid and ready are both high for the same requester; valid never waits
// on ready, ready may depend on valid. S2 holds while its addressed
// requester is not ready; S1 only loads when it is empty or S2 is moving.
module twiddle_arbiter
  import twiddle_pkg::*;
#(
  parameter int double = 0,
  parameter int NREQ   = 2,
  localparam int SZ    = SIZE(double),
  localparam int IDW   = (clog2(NREQ) < 1) ? 1 : clog2(NREQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*SZ-1:0] req_theta,
  output logic [NREQ-1:0]    req_ready,
  output logic [NREQ-1:0]    rsp_valid,
  input  logic [NREQ-1:0]    rsp_ready,
  output logic [2*SZ-1:0]    rsp_result,
  output logic               busy
`ifdef TWIDDLE_ARB_STATS_EN
  ,
  output logic [NREQ*16-1:0] grant_cnt,
  output logic [15:0]        stall_cnt
`endif
);

  logic            v1, v2;
  logic [IDW-1:0]  id1, id2;
  logic [SZ-1:0]   theta1;
  logic [2*SZ-1:0] result2;
  logic [2*SZ-1:0] tw_result;

  logic [NREQ-1:0] gnt;
  logic [IDW-1:0]  gidx;
  logic [SZ-1:0]   theta_in;
  logic            hold2;
  logic            s1_load;
  logic            accept;

  // S2 stalls when its addressed requester refuses; S1 loads when it can move.
  assign hold2   = v2 & ~rsp_ready[id2];
  assign s1_load = ~v1 | ~hold2;
  assign accept  = |gnt;

  // Arbitration is suppressed during reset and whenever S1 cannot load.
  twiddle_rr_arb #(.NREQ(NREQ)) u_arb (
    .clk (clk),
    .rst (rst),
    .req (req_valid),
    .en  (s1_load & ~rst),
    .gnt (gnt)
  );

  assign req_ready = gnt;

  // Encode the one-hot grant and select the winner's theta.
  always_comb begin
    gidx     = '0;
    theta_in = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        gidx     = IDW'(i);
        theta_in = req_theta[i*SZ +: SZ];
      end
    end
  end

  twiddle #(.double(double)) u_twiddle (
    .theta  (theta1),
    .result (tw_result)
  );

  // Stage 1: capture the granted request.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1     <= 1'b0;
      id1    <= '0;
      theta1 <= '0;
    end else if (s1_load) begin
      v1 <= accept;
      if (accept) begin
        id1    <= gidx;
        theta1 <= theta_in;
      end
    end
  end

  // Stage 2: capture the twiddle result; payload only changes on a new entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      v2      <= 1'b0;
      id2     <= '0;
      result2 <= '0;
    end else if (!hold2) begin
      v2 <= v1;
      if (v1) begin
        id2     <= id1;
        result2 <= tw_result;
      end
    end
  end

  // Response side: one-hot valid addressed by the stage-2 tag.
  always_comb begin
    rsp_valid = '0;
    if (v2) rsp_valid[id2] = 1'b1;
  end

  assign rsp_result = result2;
  assign busy       = v1 | v2;

`ifdef TWIDDLE_ARB_STATS_EN
  // Saturating per-requester accept counters and stall-cycle counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (gnt[i] && (grant_cnt[i*16 +: 16] != 16'hffff))
          grant_cnt[i*16 +: 16] <= grant_cnt[i*16 +: 16] + 16'd1;
      end
      if (hold2 && (stall_cnt != 16'hffff))
        stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_twiddle_arbiter.sv
// Bench for twiddle_arbiter (NREQ=2, single precision). Directed scenarios
// followed by a randomized phase; a queue-level model predicts grants,
// busy and response order, reference twiddle instances supply result words.
module tb_twiddle_arbiter;
  import twiddle_pkg::*;

  localparam int NREQ = 2;
  localparam int SZ   = 32;
  localparam int IDW  = 1;
  localparam int W    = IDW + 2*SZ;

  logic               clk = 1'b0;
  logic               rst;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*SZ-1:0] req_theta;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ-1:0]    rsp_valid;
  logic [NREQ-1:0]    rsp_ready;
  logic [2*SZ-1:0]    rsp_result;
  logic               busy;
`ifdef TWIDDLE_ARB_STATS_EN
  logic [NREQ*16-1:0] grant_cnt;
  logic [15:0]        stall_cnt;
`endif

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  twiddle_arbiter #(.double(0), .NREQ(NREQ)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_theta  (req_theta),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .busy       (busy)
`ifdef TWIDDLE_ARB_STATS_EN
    ,
    .grant_cnt  (grant_cnt),
    .stall_cnt  (stall_cnt)
`endif
  );

  // Direct twiddle instances, one per requester input.
  logic [2*SZ-1:0] ref_res [NREQ];
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_ref
    twiddle #(.double(0)) u_ref (
      .theta  (req_theta[gi*SZ +: SZ]),
      .result (ref_res[gi])
    );
  end

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int  total = 0;
  int  bad   = 0;
  bit  checks_on = 1'b0;
  bit  head_vis  = 1'b0;
  bit  mon_taken = 1'b0;
  int  p = 0;
  int  gcnt_m [NREQ];
  int  stall_m = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, got, want, $time);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [NREQ-1:0] exp_v;
    logic [IDW-1:0]  hid;
    mon_taken = 1'b0;
    if (checks_on) begin
      exp_v = '0;
      hid   = '0;
      if (head_vis) begin
        hid = exp_q[0][2*SZ +: IDW];
        exp_v[hid] = 1'b1;
      end
      check("rsp_valid", 64'(rsp_valid), 64'(exp_v));
      if (head_vis) begin
        check("rsp_result", rsp_result, exp_q[0][2*SZ-1:0]);
        if (!rst && rsp_ready[hid]) begin
          void'(exp_q.pop_front());
          mon_taken = 1'b1;
        end
      end
    end
  end

  // ---------------- reference model step (negedge + 1) ----------------
  task automatic model_step();
    int count_pre;
    bit hold;
    bit can_load;
    int g;
    bit nvis;
    logic [NREQ-1:0] exp_g;
`ifdef TWIDDLE_ARB_STATS_EN
    if (checks_on) begin
      for (int i = 0; i < NREQ; i++)
        check("grant_cnt", 64'(grant_cnt[i*16 +: 16]), 64'(gcnt_m[i]));
      check("stall_cnt", 64'(stall_cnt), 64'(stall_m));
    end
`endif
    count_pre = exp_q.size() + int'(mon_taken);
    if (rst) begin
      check("req_ready_rst", 64'(req_ready), 64'd0);
      if (checks_on) check("busy_rst", 64'(busy), 64'(count_pre > 0));
      exp_q.delete();
      p        = 0;
      head_vis = 1'b0;
      stall_m  = 0;
      for (int i = 0; i < NREQ; i++) gcnt_m[i] = 0;
      checks_on = 1'b1;
      return;
    end
    hold     = head_vis && !mon_taken;
    can_load = (count_pre < 2) || !hold;
    check("busy", 64'(busy), 64'(count_pre > 0));
    g = -1;
    if (can_load) begin
      for (int k = 0; k < NREQ; k++) begin
        int i;
        i = (p + k) % NREQ;
        if (g < 0 && req_valid[i]) g = i;
      end
    end
    exp_g = '0;
    if (g >= 0) exp_g[g] = 1'b1;
    check("req_ready", 64'(req_ready), 64'(exp_g));
    if (hold) stall_m++;
    nvis = exp_q.size() > 0;
    if (g >= 0) begin
      exp_q.push_back({IDW'(g), ref_res[g]});
      p = (g + 1) % NREQ;
      gcnt_m[g]++;
    end
    head_vis = nvis;
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic r, input logic [NREQ-1:0] v, input logic [NREQ-1:0] rr,
                       input logic [SZ-1:0] t0, input logic [SZ-1:0] t1);
    @(posedge clk);
    #1;
    rst       = r;
    req_valid = v;
    rsp_ready = rr;
    req_theta = {t1, t0};
    @(negedge clk);
    #1;
    model_step();
  endtask

  task automatic reset_cycles(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, '1, '1, 32'h0, 32'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < NREQ; i++) gcnt_m[i] = 0;
    rst       = 1'b1;
    req_valid = '1;
    rsp_ready = '1;
    req_theta = '0;

    // Reset with every requester asking: nothing granted, nothing busy.
    reset_cycles(2);
    check("rsp_result_rst", rsp_result, 64'd0);

    // Single request from requester 0, theta = 1.0.
    drive(1'b0, 2'b01, 2'b11, ONE_SP, 32'h0);
    for (int i = 0; i < 4; i++) drive(1'b0, 2'b00, 2'b11, 32'h0, 32'h0);

    // Round-robin: both requesters valid for 6 cycles.
    reset_cycles(1);
    for (int i = 0; i < 6; i++) drive(1'b0, 2'b11, 2'b11, ONE_SP, 32'h40000000);
    for (int i = 0; i < 4; i++) drive(1'b0, 2'b00, 2'b11, 32'h0, 32'h0);

    // Backpressure on requester 0 for 5 cycles with a pending result.
    reset_cycles(1);
    drive(1'b0, 2'b01, 2'b10, 32'h3f000000, 32'h0);
    for (int i = 0; i < 5; i++) drive(1'b0, 2'b11, 2'b10, 32'h3e800000, 32'h3e000000);
    for (int i = 0; i < 5; i++) drive(1'b0, 2'b00, 2'b11, 32'h0, 32'h0);

    // Reset while both stages are full; first accept afterwards is requester 0.
    for (int i = 0; i < 3; i++) drive(1'b0, 2'b11, 2'b00, 32'h11111111, 32'h22222222);
    drive(1'b1, 2'b11, 2'b00, 32'h0, 32'h0);
    drive(1'b0, 2'b11, 2'b11, 32'h33333333, 32'h44444444);
    check("first_grant_after_rst", 64'(req_ready), 64'h1);
    for (int i = 0; i < 4; i++) drive(1'b0, 2'b00, 2'b11, 32'h0, 32'h0);

`ifdef TWIDDLE_ARB_STATS_EN
    // Ten grants to requester 1, then three stall cycles.
    reset_cycles(1);
    for (int i = 0; i < 10; i++) drive(1'b0, 2'b10, 2'b11, 32'h0, 32'(i));
    for (int i = 0; i < 3; i++) drive(1'b0, 2'b00, 2'b00, 32'h0, 32'h0);
    for (int i = 0; i < 3; i++) drive(1'b0, 2'b00, 2'b11, 32'h0, 32'h0);
    check("grant_cnt1_directed", 64'(grant_cnt[16 +: 16]), 64'd10);
    check("stall_cnt_directed", 64'(stall_cnt), 64'd3);
`endif

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 400; n++) begin
      logic r;
      logic [NREQ-1:0] v, rr;
      r  = ($urandom_range(0, 63) == 0);
      v  = NREQ'($urandom_range(0, (1 << NREQ) - 1));
      rr = ($urandom_range(0, 3) == 0) ? NREQ'($urandom_range(0, (1 << NREQ) - 1)) : '1;
      drive(r, v, rr, $urandom, $urandom);
    end
    for (int i = 0; i < 6; i++) drive(1'b0, 2'b00, 2'b11, 32'h0, 32'h0);
    check("drained", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
